// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates ALU and LSU writebacks onto the single regfile write port. The ALU has priority, and the LSU gets an anti-starvation forced grant.
// Latency: grants are combinational, and an accepted write appears on regwrite/adr_rd/din_rd one cycle later.
// Backpressure: a denied requester holds valid/adr/data until its ready rises, and the arbiter latches nothing while a request is denied.
// Option: define REGFILE_WB_BYPASS_EN to add the fwd_rs1_hit/fwd_rs2_hit/fwd_data bypass outputs.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_adr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_adr,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        regwrite,
    output logic [4:0]  adr_rd,
    output logic [31:0] din_rd,
    input  logic [4:0]  adr_rs1,
    input  logic [4:0]  adr_rs2
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic        fwd_rs1_hit,
    output logic        fwd_rs2_hit,
    output logic [31:0] fwd_data
`endif
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
    } wb_req_t;

    generate
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
            $error("regfile_wb_arbiter: STARVE_MAX must be in 1..15");
        end
    endgenerate

    logic [CW-1:0] starve_cnt;
    logic          force_lsu;
    logic          xfer;
    wb_req_t       alu_req;
    wb_req_t       lsu_req;
    wb_req_t       sel_req;

    assign alu_req = '{adr: alu_adr, dat: alu_data};
    assign lsu_req = '{adr: lsu_adr, dat: lsu_data};

    // Grant logic: the ALU wins unless the LSU has been starved to the limit; nothing is granted in reset.
    always_comb begin
        force_lsu = lsu_valid && (starve_cnt == STARVE_LIM);
        alu_ready = !rst && alu_valid && !force_lsu;
        lsu_ready = !rst && lsu_valid && !alu_ready;
        xfer      = alu_ready || lsu_ready;
        sel_req   = alu_ready ? alu_req : lsu_req;
    end

    // Starvation counter: counts consecutive LSU denials (saturating), and clears on an LSU grant or an idle LSU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (lsu_valid && !lsu_ready) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Writeback register: a granted request appears next cycle. A write to x0 completes but does not assert regwrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite <= 1'b0;
            adr_rd   <= '0;
            din_rd   <= '0;
        end else begin
            regwrite <= xfer && (sel_req.adr != 5'd0);
            if (xfer) begin
                adr_rd <= sel_req.adr;
                din_rd <= sel_req.dat;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Bypass: forward the in-flight write to matching read ports; x0 never forwards.
    always_comb begin
        fwd_rs1_hit = regwrite && (adr_rd == adr_rs1) && (adr_rd != 5'd0);
        fwd_rs2_hit = regwrite && (adr_rd == adr_rs2) && (adr_rd != 5'd0);
        fwd_data    = din_rd;
    end
`else
    logic unused_rd_addrs;
    assign unused_rd_addrs = ^{adr_rs1, adr_rs2};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int SM = 3;

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_adr, lsu_adr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        regwrite;
    logic [4:0]  adr_rd;
    logic [31:0] din_rd;
    logic [4:0]  adr_rs1, adr_rs2;
`ifdef REGFILE_WB_BYPASS_EN
    logic        fwd_rs1_hit, fwd_rs2_hit;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: consecutive LSU refusals and the expected write-port contents.
    int          m_deny;
    logic        m_rw;
    logic [4:0]  m_adr;
    logic [31:0] m_din;

    regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_adr(alu_adr), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_adr(lsu_adr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .regwrite(regwrite), .adr_rd(adr_rd), .din_rd(din_rd),
        .adr_rs1(adr_rs1), .adr_rs2(adr_rs2)
`ifdef REGFILE_WB_BYPASS_EN
        , .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_data(fwd_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Who should win this cycle: 0 none, 1 ALU, 2 LSU.
    function automatic int model_grant();
        if (rst) return 0;
        if (alu_valid && !(lsu_valid && m_deny >= SM)) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] grant_bits(input int g);
        return (g == 1) ? 2'b10 : (g == 2) ? 2'b01 : 2'b00;
    endfunction

    task automatic model_reset();
        m_deny = 0; m_rw = 1'b0; m_adr = '0; m_din = '0;
    endtask

    task automatic model_edge(input int g);
        if (g == 1) begin
            m_rw = (alu_adr != 0); m_adr = alu_adr; m_din = alu_data;
        end else if (g == 2) begin
            m_rw = (lsu_adr != 0); m_adr = lsu_adr; m_din = lsu_data;
        end else begin
            m_rw = 1'b0;
        end
        if (lsu_valid && g != 2) m_deny = (m_deny < SM) ? m_deny + 1 : SM;
        else m_deny = 0;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        @(negedge clk);
        alu_valid = av; alu_adr = aa; alu_data = ad;
        lsu_valid = lv; lsu_adr = la; lsu_data = ld;
        #1;
    endtask

    task automatic advance(output int g);
        g = model_grant();
        @(posedge clk);
        #1;
        model_edge(g);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({alu_ready, lsu_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b want 00", {alu_ready, lsu_ready});
        end
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== 38'd0) begin
            n_bad++; $display("FAIL reset_out: got %b/%0d/%h want 0/0/0", regwrite, adr_rd, din_rd);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({regwrite, adr_rd, din_rd, alu_ready, lsu_ready} !== 40'd0) begin
            n_bad++; $display("FAIL reset_hold: got %b/%0d/%h rdy %b%b", regwrite, adr_rd, din_rd, alu_ready, lsu_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_alu_single();
        int g;
        drive(1'b1, 5'd1, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            n_bad++; $display("FAIL alu_single_rdy: got %b want 10", {alu_ready, lsu_ready});
        end
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b1, 5'd1, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL alu_single_wb: got %b/%0d/%h want 1/1/ffffffff", regwrite, adr_rd, din_rd);
        end
        drive(1'b0, 5'd9, 32'h0, 1'b0, 5'd9, 32'h0);
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b0, 5'd1, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL idle_hold: got %b/%0d/%h want 0/1/ffffffff", regwrite, adr_rd, din_rd);
        end
    endtask

    task automatic test_starvation();
        int g;
        int run = 0;
        logic [4:0]  la = 5'd10;
        logic [31:0] ld = $urandom;
        logic [1:0]  pat;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, la, ld);
            pat = (i % 4 == 3) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({alu_ready, lsu_ready} !== pat || pat !== grant_bits(model_grant())) begin
                n_bad++; $display("FAIL starve_grant[%0d]: got %b want %b", i, {alu_ready, lsu_ready}, pat);
            end
            run = (lsu_valid && !lsu_ready) ? run + 1 : 0;
            n_cmp++;
            if (run > SM) begin
                n_bad++; $display("FAIL starve_run: LSU denied %0d cycles, limit %0d", run, SM);
            end
            advance(g);
            n_cmp++;
            if ({regwrite, adr_rd, din_rd} !== {m_rw, m_adr, m_din}) begin
                n_bad++; $display("FAIL starve_wb[%0d]: got %b/%0d/%h want %b/%0d/%h", i, regwrite, adr_rd, din_rd, m_rw, m_adr, m_din);
            end
            if (g == 2) begin
                la = 5'($urandom_range(1, 31)); ld = $urandom;
            end
        end
    endtask

    task automatic test_x0();
        int g;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
            n_bad++; $display("FAIL x0_rdy: got %b want 1", lsu_ready);
        end
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b0, 5'd0, 32'h1234_5678}) begin
            n_bad++; $display("FAIL x0_wb: got %b/%0d/%h want 0/0/12345678", regwrite, adr_rd, din_rd);
        end
    endtask

    task automatic test_same_addr();
        int g;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        advance(g);
        drive(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222);
        n_cmp++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            n_bad++; $display("FAIL same_rdy1: got %b want 10", {alu_ready, lsu_ready});
        end
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b1, 5'd5, 32'h1111_1111}) begin
            n_bad++; $display("FAIL same_wb1: got %b/%0d/%h want 1/5/11111111", regwrite, adr_rd, din_rd);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h2222_2222);
        n_cmp++;
        if ({alu_ready, lsu_ready} !== 2'b01) begin
            n_bad++; $display("FAIL same_rdy2: got %b want 01", {alu_ready, lsu_ready});
        end
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b1, 5'd5, 32'h2222_2222}) begin
            n_bad++; $display("FAIL same_wb2: got %b/%0d/%h want 1/5/22222222", regwrite, adr_rd, din_rd);
        end
    endtask

    task automatic test_async_reset();
        int g;
        logic [31:0] d = $urandom;
        drive(1'b1, 5'd7, d, 1'b0, 5'd0, 32'd0);
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b1, 5'd7, d}) begin
            n_bad++; $display("FAIL arst_pre: got %b/%0d/%h want 1/7/%h", regwrite, adr_rd, din_rd, d);
        end
        #2;
        rst = 1'b1;
        lsu_valid = 1'b1; lsu_adr = 5'd9; lsu_data = 32'hA5A5_5A5A;
        #1;
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== 38'd0) begin
            n_bad++; $display("FAIL arst_out: got %b/%0d/%h want 0/0/0", regwrite, adr_rd, din_rd);
        end
        n_cmp++;
        if ({alu_ready, lsu_ready} !== 2'b00) begin
            n_bad++; $display("FAIL arst_rdy: got %b want 00", {alu_ready, lsu_ready});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({regwrite, adr_rd, din_rd, alu_ready, lsu_ready} !== 40'd0) begin
            n_bad++; $display("FAIL arst_edge: got %b/%0d/%h rdy %b%b", regwrite, adr_rd, din_rd, alu_ready, lsu_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            n_bad++; $display("FAIL arst_release_rdy: got %b want 10", {alu_ready, lsu_ready});
        end
        advance(g);
        n_cmp++;
        if ({regwrite, adr_rd, din_rd} !== {1'b1, 5'd7, d}) begin
            n_bad++; $display("FAIL arst_release_wb: got %b/%0d/%h want 1/7/%h", regwrite, adr_rd, din_rd, d);
        end
    endtask

    task automatic test_random();
        int g;
        logic        av = 0, lv = 0;
        logic [4:0]  aa = 0, la = 0;
        logic [31:0] ad = 0, ld = 0;
        logic        a_hold = 0, l_hold = 0;
        for (int i = 0; i < 300; i++) begin
            if (!a_hold) begin
                av = ($urandom_range(0, 9) < 7); aa = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!l_hold) begin
                lv = ($urandom_range(0, 9) < 7); la = 5'($urandom_range(0, 31)); ld = $urandom;
            end
            drive(av, aa, ad, lv, la, ld);
            n_cmp++;
            if ({alu_ready, lsu_ready} !== grant_bits(model_grant())) begin
                n_bad++; $display("FAIL rand_rdy[%0d]: got %b want %b", i, {alu_ready, lsu_ready}, grant_bits(model_grant()));
            end
            advance(g);
            n_cmp++;
            if ({regwrite, adr_rd, din_rd} !== {m_rw, m_adr, m_din}) begin
                n_bad++; $display("FAIL rand_wb[%0d]: got %b/%0d/%h want %b/%0d/%h", i, regwrite, adr_rd, din_rd, m_rw, m_adr, m_din);
            end
            a_hold = av && (g != 1);
            l_hold = lv && (g != 2);
        end
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    task automatic test_bypass();
        int g;
        adr_rs1 = 5'd2; adr_rs2 = 5'd3;
        drive(1'b1, 5'd2, 32'hFFFF_0000, 1'b0, 5'd0, 32'd0);
        advance(g);
        n_cmp++;
        if ({fwd_rs1_hit, fwd_rs2_hit, fwd_data} !== {1'b1, 1'b0, 32'hFFFF_0000}) begin
            n_bad++; $display("FAIL bypass: got %b/%b/%h want 1/0/ffff0000", fwd_rs1_hit, fwd_rs2_hit, fwd_data);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_adr = 5'd3; alu_data = 32'hDEAD_BEEF;
        lsu_valid = 1'b1; lsu_adr = 5'd4; lsu_data = 32'hCAFE_F00D;
        adr_rs1 = 5'd0; adr_rs2 = 5'd0;
        model_reset();
        test_reset();
        test_alu_single();
        test_starvation();
        test_x0();
        test_same_addr();
        test_async_reset();
        test_random();
`ifdef REGFILE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive cycles the LSU may be denied before it is forced a grant; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port alu_valid, input, 1 bit: ALU writeback request.
REQ-005 The block SHALL have port alu_adr, input, 5 bits: ALU destination register.
REQ-006 The block SHALL have port alu_data, input, 32 bits: ALU result.
REQ-007 The block SHALL have port alu_ready, output, 1 bit: ALU request accepted this cycle.
REQ-008 The block SHALL have port lsu_valid, input, 1 bit: load-unit writeback request.
REQ-009 The block SHALL have port lsu_adr, input, 5 bits: load destination register.
REQ-010 The block SHALL have port lsu_data, input, 32 bits: load data.
REQ-011 The block SHALL have port lsu_ready, output, 1 bit: LSU request accepted this cycle.
REQ-012 The block SHALL have port regwrite, output, 1 bit: Regfile write enable.
REQ-013 The block SHALL have port adr_rd, output, 5 bits: Regfile write address.
REQ-014 The block SHALL have port din_rd, output, 32 bits: Regfile write data.
REQ-015 The block SHALL have ports adr_rs1 and adr_rs2, input, 5 bits each: the current Regfile read addresses (used only by bypass).
REQ-016 The block SHALL have ports fwd_rs1_hit and fwd_rs2_hit, output, 1 bit each, and fwd_data, output, 32 bits: the bypass result (present only with WB_BYPASS_EN).

Function
REQ-017 The block SHALL compute the grants combinationally: force = lsu_valid and (starve_cnt == STARVE_MAX); alu_ready = alu_valid and not force; lsu_ready = lsu_valid and not alu_ready.
REQ-018 The block SHALL treat a transfer as valid and ready on the same edge; at most one transfer occurs per cycle.
REQ-019 The block SHALL require a requester with valid high and ready low to hold its valid, address and data stable; the block SHALL NOT latch a denied request.
REQ-020 The block SHALL register an accepted transfer with one cycle of latency: on the next cycle regwrite = 1 (if adr != 0), adr_rd = the accepted address, and din_rd = the accepted data.
REQ-021 The block SHALL complete a transfer to address 0 (ready asserted, adr_rd/din_rd updated) but SHALL drive regwrite = 0 for it.
REQ-022 The block SHALL drive regwrite = 0 in any cycle after which no transfer occurred, and SHALL hold adr_rd and din_rd at their previous values.
REQ-023 The block SHALL manage starve_cnt, clog2(STARVE_MAX+1) bits, as follows: it increments, saturating at STARVE_MAX, when lsu_valid=1 and lsu_ready=0; it clears to 0 on an LSU transfer or when lsu_valid=0.
REQ-024 The block SHALL NOT drop the ALU request during a forced LSU grant (alu_ready=0); the ALU wins on the next cycle if starve_cnt=0.
REQ-025 The block SHALL arbitrate both requesters targeting the same address normally; the writes occur in grant order on consecutive cycles, with no merging.

Reset
REQ-026 The block SHALL drive regwrite=0, adr_rd=0, din_rd=0 and starve_cnt=0 immediately while rst=1, independent of clk.
REQ-027 The block SHALL force alu_ready=0 and lsu_ready=0 while rst=1; a request pending when reset asserts is not accepted, and is arbitrated afresh after release.
REQ-028 The block SHALL apply the first possible transfer at the first rising edge after rst deasserts.

Configuration
REQ-029 The block SHALL use the macro REGFILE_WB_BYPASS_EN; when it is defined, fwd_rsN_hit = regwrite and (adr_rd == adr_rsN) and (adr_rd != 0), and fwd_data = din_rd, all combinational.
REQ-030 The block SHALL omit the fwd_* ports and all compare logic entirely when REGFILE_WB_BYPASS_EN is undefined; the remaining behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover this case: ALU only, alu_adr=1, data=FFFFFFFF -> alu_ready same cycle; next cycle regwrite=1, adr_rd=1, din_rd=FFFFFFFF.
REQ-032 The bench SHALL cover this case: both valid continuously, STARVE_MAX=3 -> ALU granted 3 cycles, LSU forced on the 4th, then the ALU again; the LSU is never denied more than 3 consecutive cycles.
REQ-033 The bench SHALL cover this case: LSU write to x0 with data=12345678 -> lsu_ready=1, next cycle regwrite=0, adr_rd=0.
REQ-034 The bench SHALL cover this case: rst pulsed asynchronously mid-cycle while regwrite=1 -> regwrite, adr_rd and din_rd go to 0 before the next edge; both readys are 0 during reset.
REQ-035 The bench SHALL cover this case, with REGFILE_WB_BYPASS_EN: write x2=FFFF0000 with adr_rs1=2, adr_rs2=3 -> fwd_rs1_hit=1, fwd_data=FFFF0000, fwd_rs2_hit=0.
REQ-036 The bench SHALL cover this case: ALU and LSU both target x5 with ALU=11111111, LSU=22222222 -> x5 is written 11111111 first, then 22222222 the following cycle.
